// File: rtl/axi4_req_flit_arbiter.sv
// AXI4 AW/W/AR request channels round-robin arbitrated onto one registered NoC flit stream.
// Optional W-burst locking (contiguous bursts) enabled by defining AXI4_ARB_WBURST_LOCK_EN.
module axi4_req_flit_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned ID_W   = 8,
  localparam int unsigned ADDR_W = 32,
  localparam int unsigned DATA_W = 64,
  localparam int unsigned STRB_W = 8,
  localparam int unsigned FLIT_W = 92
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              aw_valid,
  output logic              aw_ready,
  input  logic [ID_W-1:0]   aw_id,
  input  logic [ADDR_W-1:0] aw_addr,
  input  logic [7:0]        aw_len,
  input  logic [2:0]        aw_size,
  input  logic [1:0]        aw_burst,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] w_data,
  input  logic [STRB_W-1:0] w_strb,
  input  logic              w_last,
  input  logic              ar_valid,
  output logic              ar_ready,
  input  logic [ID_W-1:0]   ar_id,
  input  logic [ADDR_W-1:0] ar_addr,
  input  logic [7:0]        ar_len,
  input  logic [2:0]        ar_size,
  input  logic [1:0]        ar_burst,
  output logic              flit_valid,
  input  logic              flit_ready,
  output logic [2:0]        flit_chan,
  output logic [FLIT_W-1:0] flit_data
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [2:0] CHAN_AW = 3'b001;
  localparam logic [2:0] CHAN_W  = 3'b011;
  localparam logic [2:0] CHAN_AR = 3'b010;

  typedef enum logic [1:0] {RR_AW, RR_W, RR_AR} rr_t;

  rr_t              rr_last;
  logic [CNT_W-1:0] out_cnt;
  logic             lock;
  logic             can_load;
  logic             elig_aw, elig_w, elig_ar;
  logic             grant_aw, grant_w, grant_ar;
  logic [2:0]       next_chan;
  logic [FLIT_W-1:0] next_data;

`ifdef AXI4_ARB_WBURST_LOCK_EN
  typedef enum logic {LOCK_IDLE, LOCK_WBURST} lock_t;
  lock_t lock_state;

  // Once a burst starts, hold the stream for W until its last beat is granted.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      lock_state <= LOCK_IDLE;
    end else if (grant_w) begin
      lock_state <= w_last ? LOCK_IDLE : LOCK_WBURST;
    end
  end

  assign lock = (lock_state == LOCK_WBURST);
`else
  assign lock = 1'b0;
`endif

  assign can_load = RST_N & (~flit_valid | flit_ready);
  assign elig_aw  = aw_valid & (out_cnt < CNT_W'(MAX_OUTSTANDING)) & ~lock;
  assign elig_w   = w_valid & (out_cnt != '0);
  assign elig_ar  = ar_valid & ~lock;

  // Round-robin: search starts at the channel after the last granted one.
  always_comb begin
    grant_aw = 1'b0;
    grant_w  = 1'b0;
    grant_ar = 1'b0;
    if (can_load) begin
      case (rr_last)
        RR_AW: begin
          if (elig_w)       grant_w  = 1'b1;
          else if (elig_ar) grant_ar = 1'b1;
          else if (elig_aw) grant_aw = 1'b1;
        end
        RR_W: begin
          if (elig_ar)      grant_ar = 1'b1;
          else if (elig_aw) grant_aw = 1'b1;
          else if (elig_w)  grant_w  = 1'b1;
        end
        default: begin
          if (elig_aw)      grant_aw = 1'b1;
          else if (elig_w)  grant_w  = 1'b1;
          else if (elig_ar) grant_ar = 1'b1;
        end
      endcase
    end
  end

  assign aw_ready = grant_aw;
  assign w_ready  = grant_w;
  assign ar_ready = grant_ar;

  always_comb begin
    next_chan = CHAN_AR;
    next_data = {39'b0, ar_id, ar_addr, ar_len, ar_size, ar_burst};
    if (grant_aw) begin
      next_chan = CHAN_AW;
      next_data = {39'b0, aw_id, aw_addr, aw_len, aw_size, aw_burst};
    end else if (grant_w) begin
      next_chan = CHAN_W;
      next_data = {19'b0, w_last, w_strb, w_data};
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      flit_valid <= 1'b0;
      flit_chan  <= 3'b000;
      flit_data  <= '0;
    end else if (grant_aw | grant_w | grant_ar) begin
      flit_valid <= 1'b1;
      flit_chan  <= next_chan;
      flit_data  <= next_data;
    end else if (flit_ready) begin
      flit_valid <= 1'b0;
    end
  end

  // Writes whose AW has been sent but whose W burst has not yet completed.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      out_cnt <= '0;
    end else begin
      case ({grant_aw, grant_w & w_last})
        2'b10:   out_cnt <= out_cnt + CNT_W'(1);
        2'b01:   out_cnt <= out_cnt - CNT_W'(1);
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rr_last <= RR_AR;
    end else if (grant_aw) begin
      rr_last <= RR_AW;
    end else if (grant_w) begin
      rr_last <= RR_W;
    end else if (grant_ar) begin
      rr_last <= RR_AR;
    end
  end

endmodule

// File: tb/tb_axi4_req_flit_arbiter.sv
// Self-checking bench for axi4_req_flit_arbiter: directed scenarios plus random traffic
// checked each cycle against a rule-level reference model.
module tb_axi4_req_flit_arbiter;

  localparam int MAXO = 4;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        aw_valid, aw_ready, w_valid, w_ready, ar_valid, ar_ready;
  logic [7:0]  aw_id, aw_len, ar_id, ar_len, w_strb;
  logic [31:0] aw_addr, ar_addr;
  logic [2:0]  aw_size, ar_size;
  logic [1:0]  aw_burst, ar_burst;
  logic [63:0] w_data;
  logic        w_last;
  logic        flit_valid, flit_ready;
  logic [2:0]  flit_chan;
  logic [91:0] flit_data;

  always #5 CLK = ~CLK;

  axi4_req_flit_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
    .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .flit_valid(flit_valid), .flit_ready(flit_ready), .flit_chan(flit_chan), .flit_data(flit_data)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: channel index 0=AW, 1=W, 2=AR
  int          m_cnt, m_rr;
  bit          m_lock, m_valid;
  logic [2:0]  m_chan;
  logic [91:0] m_data;
  logic [2:0]  obs_q[$];
  logic [2:0]  exp_q[$];
  bit          hs_aw, hs_w, hs_ar;
  int          w_left;

  function automatic logic [91:0] pack_a(logic [7:0] id, logic [31:0] addr, logic [7:0] len,
                                         logic [2:0] size, logic [1:0] burst);
    return (92'(id) << 45) | (92'(addr) << 13) | (92'(len) << 5) | (92'(size) << 2) | 92'(burst);
  endfunction

  function automatic logic [91:0] pack_w(logic last, logic [7:0] strb, logic [63:0] data);
    return (92'(last) << 72) | (92'(strb) << 64) | 92'(data);
  endfunction

  function automatic logic [2:0] code(int c);
    case (c)
      0:       return 3'b001;
      1:       return 3'b011;
      default: return 3'b010;
    endcase
  endfunction

  task automatic chk(string tag, logic [95:0] obs, logic [95:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_rr = 2; m_lock = 0; m_valid = 0; m_chan = '0; m_data = '0;
  endtask

  // One clock: check readies and output against the model, then advance the model.
  task automatic step();
    int g;
    bit can;
    bit el[3];
    #2;
    if (!RST_N) begin
      chk("rst_aw_ready", 96'(aw_ready), 96'(0));
      chk("rst_w_ready", 96'(w_ready), 96'(0));
      chk("rst_ar_ready", 96'(ar_ready), 96'(0));
      hs_aw = 0; hs_w = 0; hs_ar = 0;
      @(posedge CLK);
      model_reset();
      #3;
      return;
    end
    can   = !m_valid || flit_ready;
    el[0] = aw_valid && (m_cnt < MAXO) && !m_lock;
    el[1] = w_valid && (m_cnt > 0);
    el[2] = ar_valid && !m_lock;
    g = -1;
    if (can)
      for (int k = 1; k <= 3; k++)
        if (g < 0 && el[(m_rr + k) % 3]) g = (m_rr + k) % 3;
    chk("aw_ready", 96'(aw_ready), 96'(g == 0));
    chk("w_ready", 96'(w_ready), 96'(g == 1));
    chk("ar_ready", 96'(ar_ready), 96'(g == 2));
    chk("flit_valid", 96'(flit_valid), 96'(m_valid));
    if (m_valid) begin
      chk("flit_chan", 96'(flit_chan), 96'(m_chan));
      chk("flit_data", 96'(flit_data), 96'(m_data));
    end
    if (flit_valid && flit_ready) obs_q.push_back(flit_chan);
    hs_aw = aw_valid && aw_ready;
    hs_w  = w_valid && w_ready;
    hs_ar = ar_valid && ar_ready;
    if (g >= 0) begin
      m_valid = 1;
      m_chan  = code(g);
      case (g)
        0:       m_data = pack_a(aw_id, aw_addr, aw_len, aw_size, aw_burst);
        1:       m_data = pack_w(w_last, w_strb, w_data);
        default: m_data = pack_a(ar_id, ar_addr, ar_len, ar_size, ar_burst);
      endcase
      m_rr = g;
    end else if (flit_ready) begin
      m_valid = 0;
    end
    if (g == 0) m_cnt++;
    if (g == 1 && w_last) m_cnt--;
`ifdef AXI4_ARB_WBURST_LOCK_EN
    if (g == 1) m_lock = !w_last;
`endif
    @(posedge CLK);
    #3;
  endtask

  // Step until n flits have left the output, advancing handshaken channels.
  task automatic run(int n, int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      if (hs_aw) aw_valid = 0;
      if (hs_ar) ar_valid = 0;
      if (hs_w) begin
        w_left--;
        if (w_left == 0) w_valid = 0;
        else begin
          w_last = (w_left == 1);
          w_data = {$urandom(), $urandom()};
        end
      end
      if (obs_q.size() >= n) done = 1;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $error("FAIL timeout: observed %0d flits expected %0d", obs_q.size(), n);
    end
  endtask

  task automatic chk_seq(string tag);
    chk({tag, "_len"}, 96'(obs_q.size()), 96'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < obs_q.size()) chk($sformatf("%s_%0d", tag, i), 96'(obs_q[i]), 96'(exp_q[i]));
  endtask

  task automatic rand_fields();
    aw_id = 8'($urandom()); aw_addr = $urandom(); aw_len = 8'($urandom());
    aw_size = 3'($urandom()); aw_burst = 2'($urandom());
    ar_id = 8'($urandom()); ar_addr = $urandom(); ar_len = 8'($urandom());
    ar_size = 3'($urandom()); ar_burst = 2'($urandom());
    w_data = {$urandom(), $urandom()}; w_strb = 8'($urandom());
  endtask

  task automatic do_reset();
    aw_valid = 0; w_valid = 0; ar_valid = 0; w_last = 0; flit_ready = 1;
    RST_N = 0;
    step();
    step();
    RST_N = 1;
    obs_q.delete();
  endtask

  initial begin
    model_reset();
    rand_fields();
    do_reset();
    chk("rst_flit_valid", 96'(flit_valid), 96'(0));
    chk("rst_flit_chan", 96'(flit_chan), 96'(0));
    chk("rst_flit_data", 96'(flit_data), 96'(0));

    // All three channels requesting after reset: AW, then W, then AR
    aw_valid = 1; ar_valid = 1; w_valid = 1; w_left = 1; w_last = 1;
    run(3, 20);
    exp_q.delete(); exp_q.push_back(3'b001); exp_q.push_back(3'b011); exp_q.push_back(3'b010);
    chk_seq("t1_order");

    // W alone with nothing outstanding is never granted
    do_reset();
    w_valid = 1; w_last = 1; w_left = 1;
    repeat (20) step();
    chk("t2_w_ready", 96'(w_ready), 96'(0));
    chk("t2_flit_valid", 96'(flit_valid), 96'(0));
    w_valid = 0;

    // Outstanding limit: 4 AWs pass, 5th blocked until a W burst completes
    do_reset();
    for (int a = 0; a < 4; a++) begin
      aw_valid = 1; aw_len = 8'd0;
      run(a + 1, 10);
    end
    aw_valid = 1;
    repeat (5) begin
      step();
      chk("t3_aw_blocked", 96'(aw_ready), 96'(0));
    end
    w_valid = 1; w_left = 1; w_last = 1;
    run(5, 20);
    run(6, 20);
    exp_q.delete();
    repeat (4) exp_q.push_back(3'b001);
    exp_q.push_back(3'b011); exp_q.push_back(3'b001);
    chk_seq("t3_order");

    // Backpressure: pending flit held stable, nothing granted, no loss or duplication
    do_reset();
    aw_id = 8'h3C; aw_addr = 32'h1000_0040; aw_len = 8'd2; aw_size = 3'd2; aw_burst = 2'd1;
    flit_ready = 0; aw_valid = 1; ar_valid = 1;
    step();
    if (hs_aw) aw_valid = 0;
    repeat (5) begin
      step();
      chk("t4_hold_chan", 96'(flit_chan), 96'(3'b001));
      chk("t4_hold_data", 96'(flit_data), 96'(pack_a(8'h3C, 32'h1000_0040, 8'd2, 3'd2, 2'd1)));
      chk("t4_ar_ready", 96'(ar_ready), 96'(0));
    end
    flit_ready = 1;
    run(2, 10);
    repeat (3) step();
    exp_q.delete(); exp_q.push_back(3'b001); exp_q.push_back(3'b010);
    chk_seq("t4_order");

    // Burst of 4 W beats competing with AR
    do_reset();
    aw_len = 8'd3; aw_valid = 1; ar_valid = 1;
    w_valid = 1; w_left = 4; w_last = 0;
    run(6, 40);
    exp_q.delete();
`ifdef AXI4_ARB_WBURST_LOCK_EN
    exp_q.push_back(3'b001); repeat (4) exp_q.push_back(3'b011); exp_q.push_back(3'b010);
`else
    exp_q.push_back(3'b001); exp_q.push_back(3'b011); exp_q.push_back(3'b010);
    repeat (3) exp_q.push_back(3'b011);
`endif
    chk_seq("t5_order");

    // Payload packing
    do_reset();
    aw_id = 8'hA5; aw_addr = 32'hDEADBEEF; aw_len = 8'd7; aw_size = 3'd3; aw_burst = 2'd1;
    aw_valid = 1;
    step();
    aw_valid = 0;
    chk("t6_aw_chan", 96'(flit_chan), 96'(3'b001));
    chk("t6_aw_data", 96'(flit_data), 96'({39'b0, 8'hA5, 32'hDEADBEEF, 8'h07, 3'b011, 2'b01}));
    w_data = 64'h0123456789ABCDEF; w_strb = 8'hFF; w_last = 1; w_valid = 1;
    step();
    w_valid = 0;
    chk("t6_w_chan", 96'(flit_chan), 96'(3'b011));
    chk("t6_w_data", 96'(flit_data), 96'({19'b0, 1'b1, 8'hFF, 64'h0123456789ABCDEF}));
    step();

    // Random traffic including dropped valids, backpressure and occasional mid-burst reset
    for (int i = 0; i < 3000; i++) begin
      rand_fields();
      aw_valid   = ($urandom_range(0, 2) == 0);
      w_valid    = ($urandom_range(0, 3) != 0);
      ar_valid   = ($urandom_range(0, 2) == 0);
      w_last     = ($urandom_range(0, 2) == 0);
      flit_ready = ($urandom_range(0, 3) != 0);
      RST_N      = ($urandom_range(0, 299) != 0);
      step();
    end
    RST_N = 1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
